// File: rtl/sync_fifo_param_if.sv
// Bundle of the FIFO control, data and status signals.
// master: producer/consumer side; slave: the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              clr;
  logic              wn;
  logic [DATA_W-1:0] data_in;
  logic              rn;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wn, data_in, rn,
    input  data_out, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  clr, wn, data_in, rn,
    output data_out, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO using all 2**ADDR_W entries, with thresholds,
// sticky error flags, flush and optional FWFT read.
// Ports: clk, reset (async, active high), bus (slave modport).
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic clk,
  input  logic reset,
  sync_fifo_param_if.slave bus
);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     cnt;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf;
  logic              unf;

  // Wrap bit makes the difference span 0..DEPTH.
  assign cnt = wptr - rptr;

  assign bus.count        = cnt;
  assign bus.full         = (cnt == DEPTH_P);
  assign bus.empty        = (cnt == '0);
  assign bus.almost_full  = (cnt >= AF_P);
  assign bus.almost_empty = (cnt <= AE_P);
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;

  assign wr_ok = bus.wn && !bus.full;
  assign rd_ok = bus.rn && !bus.empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (bus.clr) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (bus.wn && bus.full) ovf <= 1'b1;
      if (bus.rn && bus.empty) unf <= 1'b1;
    end
  end

  // Storage is never cleared; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (!reset && !bus.clr && wr_ok)
      mem[wptr[ADDR_W-1:0]] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem[rptr[ADDR_W-1:0]];
    end else begin : g_reg
      logic [DATA_W-1:0] dout;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          dout <= '0;
        else if (bus.clr)
          dout <= '0;
        else if (rd_ok)
          dout <= mem[rptr[ADDR_W-1:0]];
      end
      assign bus.data_out = dout;
    end
  endgenerate
endmodule
